sprite_rom_arbiter: RTL

- Shares one combinational sprite bitmap ROM (4-bit row address in, 8-bit row bits out) among NUM_REQ sprite renderers.
- Each renderer issues one row fetch per scanline during the hsync load window.
- The arbiter grants round-robin, drives the ROM address, latches the row bits and returns them with a one-cycle ack to the winning requester.
- Sits between the per-sprite renderers and the single bitmap ROM in the game top level.

---
 rtl/sprite_rom_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares one combinational sprite bitmap ROM among NUM_REQ sprite renderers.
// Each renderer raises req (level, held until ack) with a row address. The
// arbiter picks a winner, registers the ROM address, latches the returned row
// on the next cycle and pulses a one-hot ack alongside the latched row.
//
// Configuration macro:
//   SPRITE_ARB_FIXED_PRIORITY_EN  defined   -> fixed priority, lowest index wins
//                                 undefined -> round-robin (default)
//
// Ports:
//   clk       in   pixel clock
//   reset     in   asynchronous, active-low reset
//   req       in   [NUM_REQ]         per-requester fetch request
//   req_addr  in   [NUM_REQ*ADDR_W]  packed row addresses, requester i at
//                                    [i*ADDR_W +: ADDR_W]
//   rom_addr  out  [ADDR_W]          registered address to shared ROM
//   rom_bits  in   [DATA_W]          ROM row, combinational from rom_addr
//   ack       out  [NUM_REQ]         one-hot single-cycle completion pulse
//   rd_data   out  [DATA_W]          latched ROM row, held between fetches
//   busy      out                    high while a fetch is in flight
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_bits,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [IDX_W-1:0]    win;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

`ifndef SPRITE_ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]    last_q, last_d;
    int                  rr_idx;
`endif

    // Unpack the flat address bus into one entry per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // The requester being acked right now still has req high; mask it so the
    // same request is not granted twice.
    assign eligible = req & ~ack_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
`ifdef SPRITE_ARB_FIXED_PRIORITY_EN
        // Descending scan so the lowest set index is the last one written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                found = 1'b1;
                win   = IDX_W'(k);
            end
        end
`else
        rr_idx = 0;
        // Search starts just after the last winner and wraps modulo NUM_REQ.
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = int'(last_q) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!found && eligible[rr_idx[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = rr_idx[IDX_W-1:0];
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        sel_d      = sel_q;
        ack_d      = '0;
        rd_data_d  = rd_data_q;
`ifndef SPRITE_ARB_FIXED_PRIORITY_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    rom_addr_d = addr_arr[win];
                    sel_d      = win;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                rd_data_d    = rom_bits;
                ack_d[sel_q] = 1'b1;
`ifndef SPRITE_ARB_FIXED_PRIORITY_EN
                last_d       = sel_q;
`endif
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            sel_q      <= '0;
            ack_q      <= '0;
            rd_data_q  <= '0;
`ifndef SPRITE_ARB_FIXED_PRIORITY_EN
            last_q     <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            sel_q      <= sel_d;
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
`ifndef SPRITE_ARB_FIXED_PRIORITY_EN
            last_q     <= last_d;
`endif
        end
    end

    assign rom_addr = rom_addr_q;
    assign ack      = ack_q;
    assign rd_data  = rd_data_q;
    assign busy     = (state_q == FETCH);

endmodule
